// File: rtl/game_pkg.sv
// Shared types and display defaults for the game blocks (ship, enemies, renderer).
package game_pkg;

  localparam int unsigned CW = 12;
  typedef logic [CW-1:0] coord_t;

  localparam int unsigned DISP_W = 640;
  localparam int unsigned DISP_H = 480;

  typedef enum logic [1:0] {
    MARCH,
    RESPAWN_WAIT,
    GAME_OVER
  } wave_state_t;

endpackage

// File: rtl/box_overlap.sv
// Strict axis-aligned overlap of two boxes; touching edges do not count.
module box_overlap
  import game_pkg::*;
(
  input  coord_t a_x1_i,
  input  coord_t a_x2_i,
  input  coord_t a_y1_i,
  input  coord_t a_y2_i,
  input  coord_t b_x1_i,
  input  coord_t b_x2_i,
  input  coord_t b_y1_i,
  input  coord_t b_y2_i,
  output logic   overlap_o
);

  always_comb begin
    overlap_o = (a_x1_i < b_x2_i) && (a_x2_i > b_x1_i) &&
                (a_y1_i < b_y2_i) && (a_y2_i > b_y1_i);
  end

endmodule

// File: rtl/enemy_wave.sv
// Row of N marching enemies: bounce/step-down at the edges, bullet kills,
// score/wave bookkeeping, respawn delay and a latched game-over.
module enemy_wave
  import game_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned E_SIZE    = 20,
  parameter int unsigned SPACING   = 120,
  parameter int unsigned IX0       = 80,
  parameter int unsigned IY        = 100,
  parameter int unsigned STEP_DOWN = 16,
  parameter int unsigned RESPAWN   = 60,
  parameter int unsigned D_WIDTH   = DISP_W,
  parameter int unsigned D_HEIGHT  = DISP_H
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ani_stb,
  input  logic            i_animate,
  input  logic            i_paused,
  input  logic [11:0]     i_x1,
  input  logic [11:0]     i_x2,
  input  logic [11:0]     i_y1,
  input  logic [11:0]     i_y2,
  input  logic [11:0]     i_bx1,
  input  logic [11:0]     i_bx2,
  input  logic [11:0]     i_by1,
  input  logic [11:0]     i_by2,
  input  logic            i_firing,
  output logic [12*N-1:0] o_ex1,
  output logic [12*N-1:0] o_ex2,
  output logic [11:0]     o_ey1,
  output logic [11:0]     o_ey2,
  output logic [N-1:0]    o_alive,
  output logic            o_hit,
  output logic [15:0]     o_score,
  output logic [7:0]      o_wave,
  output logic            o_game_over
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = $clog2(RESPAWN + 1);

  localparam coord_t ES    = coord_t'(E_SIZE);
  localparam coord_t SD    = coord_t'(STEP_DOWN);
  localparam coord_t X_RST = coord_t'(IX0);
  localparam coord_t Y_RST = coord_t'(IY);
  localparam coord_t R_LIM = coord_t'(D_WIDTH - 1);
  localparam coord_t B_LIM = coord_t'(D_HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN - 1);

  wave_state_t      state_q, state_d;
  coord_t           base_x_q, base_x_d;
  coord_t           row_y_q, row_y_d;
  logic             dir_q, dir_d;
  logic [N-1:0]     alive_q, alive_d;
  logic [15:0]      score_q, score_d;
  logic [7:0]       wave_q, wave_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;

  logic   q;
  coord_t ex1 [N];
  coord_t ex2 [N];
  coord_t ey1, ey2;
  logic [N-1:0] bul_ov, ply_ov, hit_vec;

  assign q   = i_animate & i_ani_stb & ~i_paused;
  assign ey1 = row_y_q - ES;
  assign ey2 = row_y_q + ES;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      ex1[i] = base_x_q + coord_t'(i * SPACING) - ES;
      ex2[i] = base_x_q + coord_t'(i * SPACING) + ES;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_enemy
    box_overlap u_bullet (
      .a_x1_i   (i_bx1),
      .a_x2_i   (i_bx2),
      .a_y1_i   (i_by1),
      .a_y2_i   (i_by2),
      .b_x1_i   (ex1[g]),
      .b_x2_i   (ex2[g]),
      .b_y1_i   (ey1),
      .b_y2_i   (ey2),
      .overlap_o(bul_ov[g])
    );

    box_overlap u_player (
      .a_x1_i   (i_x1),
      .a_x2_i   (i_x2),
      .a_y1_i   (i_y1),
      .a_y2_i   (i_y2),
      .b_x1_i   (ex1[g]),
      .b_x2_i   (ex2[g]),
      .b_y1_i   (ey1),
      .b_y2_i   (ey2),
      .overlap_o(ply_ov[g])
    );

    assign o_ex1[12*g +: 12] = ex1[g];
    assign o_ex2[12*g +: 12] = ex2[g];
  end

  // A kill is refused while the previous kill's pulse is still out, so o_hit
  // can never stay high across two cycles even with back-to-back strobes.
  assign hit_vec = alive_q & bul_ov & {N{i_firing & ~hit_q}};

  logic             kill_any;
  logic [IDX_W-1:0] kill_idx;
  logic [N-1:0]     kill_mask;
  logic [N-1:0]     alive_after;

  always_comb begin
    kill_any  = 1'b0;
    kill_idx  = '0;
    kill_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (hit_vec[i] && !kill_any) begin
        kill_any = 1'b1;
        kill_idx = IDX_W'(i);
      end
    end
    if (kill_any) kill_mask[kill_idx] = 1'b1;
    alive_after = alive_q & ~kill_mask;
  end

  // Edge test uses the survivors of this strobe's kill, on pre-move positions.
  logic             any_left;
  logic [IDX_W-1:0] left_idx, right_idx;
  coord_t           left_edge, right_edge;
  logic             bounce, lose;

  always_comb begin
    any_left  = 1'b0;
    left_idx  = '0;
    right_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (alive_after[i]) begin
        if (!any_left) left_idx = IDX_W'(i);
        any_left  = 1'b1;
        right_idx = IDX_W'(i);
      end
    end
    left_edge  = ex1[left_idx];
    right_edge = ex2[right_idx];
    bounce     = dir_q ? (left_edge <= coord_t'(1)) : (right_edge >= R_LIM);
    lose       = (|(alive_q & ply_ov)) || (ey2 >= B_LIM);
  end

  always_comb begin
    state_d  = state_q;
    base_x_d = base_x_q;
    row_y_d  = row_y_q;
    dir_d    = dir_q;
    alive_d  = alive_q;
    score_d  = score_q;
    wave_d   = wave_q;
    cnt_d    = cnt_q;
    hit_d    = 1'b0;
    if (q) begin
      case (state_q)
        MARCH: begin
          if (lose) begin
            state_d = GAME_OVER;
          end else begin
            if (kill_any) begin
              alive_d = alive_after;
              score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
              hit_d   = 1'b1;
            end
            if (!any_left) begin
              state_d = RESPAWN_WAIT;
              cnt_d   = '0;
            end else if (bounce) begin
              dir_d   = ~dir_q;
              row_y_d = row_y_q + SD;
            end else if (dir_q) begin
              base_x_d = base_x_q - coord_t'(1);
            end else begin
              base_x_d = base_x_q + coord_t'(1);
            end
          end
        end
        RESPAWN_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            alive_d  = '1;
            base_x_d = X_RST;
            row_y_d  = Y_RST;
            dir_d    = 1'b0;
            wave_d   = wave_q + 8'd1;
            state_d  = MARCH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GAME_OVER: ;
        default: state_d = MARCH;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= MARCH;
      base_x_q <= X_RST;
      row_y_q  <= Y_RST;
      dir_q    <= 1'b0;
      alive_q  <= '1;
      score_q  <= '0;
      wave_q   <= '0;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_x_q <= base_x_d;
      row_y_q  <= row_y_d;
      dir_q    <= dir_d;
      alive_q  <= alive_d;
      score_q  <= score_d;
      wave_q   <= wave_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
    end
  end

  assign o_ey1       = ey1;
  assign o_ey2       = ey2;
  assign o_alive     = alive_q;
  assign o_hit       = hit_q;
  assign o_score     = score_q;
  assign o_wave      = wave_q;
  assign o_game_over = (state_q == GAME_OVER);

endmodule

// File: tb/tb_enemy_wave.sv
// Directed bench for enemy_wave: expectations queued per step, popped and compared after each step.
module tb_enemy_wave;

  logic        clk = 1'b0;
  logic        rst, ani_stb, animate, paused, firing;
  logic [11:0] x1, x2, y1, y2, bx1, bx2, by1, by2;
  logic [47:0] ex1, ex2;
  logic [11:0] ey1, ey2;
  logic [3:0]  alive;
  logic        hit, go;
  logic [15:0] score;
  logic [7:0]  wave;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  enemy_wave #(
    .N(4), .E_SIZE(20), .SPACING(120), .IX0(80), .IY(100),
    .STEP_DOWN(16), .RESPAWN(60), .D_WIDTH(640), .D_HEIGHT(480)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(ani_stb), .i_animate(animate),
    .i_paused(paused),
    .i_x1(x1), .i_x2(x2), .i_y1(y1), .i_y2(y2),
    .i_bx1(bx1), .i_bx2(bx2), .i_by1(by1), .i_by2(by2),
    .i_firing(firing),
    .o_ex1(ex1), .o_ex2(ex2), .o_ey1(ey1), .o_ey2(ey2),
    .o_alive(alive), .o_hit(hit), .o_score(score), .o_wave(wave),
    .o_game_over(go)
  );

  function automatic logic [11:0] e_x1(input int i);
    return ex1[12*i +: 12];
  endfunction

  function automatic logic [11:0] e_x2(input int i);
    return ex2[12*i +: 12];
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed %0h required <queued entry>", act);
    end else begin
      e = sb.pop_front();
      assert (act === e.v) else begin
        errors++;
        $error("FAIL %s: observed %0h required %0h", e.tag, act, e.v);
      end
    end
  endtask

  task automatic strobe(input int n);
    repeat (n) begin
      @(negedge clk);
      ani_stb = 1'b1;
      @(negedge clk);
      ani_stb = 1'b0;
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_bullet(input int a, input int b, input int c, input int d);
    bx1 = 12'(a); bx2 = 12'(b); by1 = 12'(c); by2 = 12'(d);
  endtask

  task automatic set_player(input int a, input int b, input int c, input int d);
    x1 = 12'(a); x2 = 12'(b); y1 = 12'(c); y2 = 12'(d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ani_stb = 1'b0; animate = 1'b1; paused = 1'b0; firing = 1'b0;
    set_player(0, 0, 0, 0);
    set_bullet(0, 0, 0, 0);
    do_reset;

    push("rst_alive", 4'hF); push("rst_e0x1", 60); push("rst_e0x2", 100);
    push("rst_ey1", 80); push("rst_ey2", 120); push("rst_score", 0);
    push("rst_wave", 0); push("rst_go", 0); push("rst_hit", 0);
    pop_chk(alive); pop_chk(e_x1(0)); pop_chk(e_x2(0));
    pop_chk(ey1); pop_chk(ey2); pop_chk(score);
    pop_chk(wave); pop_chk(go); pop_chk(hit);

    // March right to the edge, bounce, then step left
    push("march_e3x2", 639);
    strobe(179);
    pop_chk(e_x2(3));
    push("bounce_ey1", 96); push("bounce_e0x1", 239);
    strobe(1);
    pop_chk(ey1); pop_chk(e_x1(0));
    push("left_e0x1", 238);
    strobe(1);
    pop_chk(e_x1(0));

    paused = 1'b1;
    push("pause_e0x1", 238); push("pause_ey1", 96);
    strobe(10);
    paused = 1'b0;
    pop_chk(e_x1(0)); pop_chk(ey1);
    animate = 1'b0;
    push("noanim_e0x1", 238);
    strobe(5);
    animate = 1'b1;
    pop_chk(e_x1(0));

    // Bullet over enemy 1 only
    do_reset;
    set_bullet(190, 210, 90, 110);
    firing = 1'b0;
    push("nofire_alive", 4'hF); push("nofire_score", 0); push("nofire_hit", 0);
    strobe(1);
    pop_chk(alive); pop_chk(score); pop_chk(hit);
    firing = 1'b1;
    push("hit_alive", 4'hD); push("hit_score", 1); push("hit_pulse", 1);
    strobe(1);
    pop_chk(alive); pop_chk(score); pop_chk(hit);
    push("hit_pulse_end", 0);
    @(negedge clk);
    pop_chk(hit);
    firing = 1'b0;

    // Bullet over enemies 1 and 2: lowest index wins, then clear the wave
    do_reset;
    set_bullet(210, 310, 90, 110);
    firing = 1'b1;
    push("lowest_alive", 4'hD); push("lowest_score", 1);
    strobe(1);
    pop_chk(alive); pop_chk(score);
    set_bullet(0, 639, 0, 479);
    push("clr1_alive", 4'hC);
    strobe(1);
    pop_chk(alive);
    push("clr2_alive", 4'h8);
    strobe(1);
    pop_chk(alive);
    push("clr3_alive", 4'h0); push("clr_score", 4); push("clr_e0x1", 63);
    strobe(1);
    pop_chk(alive); pop_chk(score); pop_chk(e_x1(0));
    firing = 1'b0;
    push("resp_alive", 0); push("resp_e0x1", 63); push("resp_wave", 0);
    strobe(59);
    pop_chk(alive); pop_chk(e_x1(0)); pop_chk(wave);
    push("resp_done_alive", 4'hF); push("resp_done_e0x1", 60);
    push("resp_done_ey1", 80); push("resp_done_wave", 1); push("resp_done_score", 4);
    strobe(1);
    pop_chk(alive); pop_chk(e_x1(0)); pop_chk(ey1); pop_chk(wave); pop_chk(score);

    // Player collision beats a same-strobe kill
    set_player(50, 110, 70, 130);
    set_bullet(190, 210, 90, 110);
    firing = 1'b1;
    push("go_flag", 1); push("go_alive", 4'hF); push("go_score", 4);
    push("go_hit", 0); push("go_e0x1", 60);
    strobe(1);
    pop_chk(go); pop_chk(alive); pop_chk(score); pop_chk(hit); pop_chk(e_x1(0));
    push("frz_e0x1", 60); push("frz_ey1", 80); push("frz_alive", 4'hF);
    push("frz_score", 4); push("frz_go", 1); push("frz_wave", 1);
    strobe(20);
    pop_chk(e_x1(0)); pop_chk(ey1); pop_chk(alive);
    pop_chk(score); pop_chk(go); pop_chk(wave);
    firing = 1'b0;
    set_player(0, 0, 0, 0);
    do_reset;
    push("rst2_go", 0); push("rst2_score", 0); push("rst2_wave", 0);
    push("rst2_alive", 4'hF); push("rst2_e0x1", 60); push("rst2_ey1", 80);
    pop_chk(go); pop_chk(score); pop_chk(wave); pop_chk(alive);
    pop_chk(e_x1(0)); pop_chk(ey1);

    // Row reaches the bottom: loss fires once the bottom edge is >= 479
    for (int k = 0; k < 8000 && !go; k++) strobe(1);
    push("bottom_go", 1); push("bottom_ey2", 488); push("bottom_ey1", 448);
    pop_chk(go); pop_chk(ey2); pop_chk(ey1);

    // Score saturation
    do_reset;
    @(negedge clk);
    force dut.score_q = 16'hFFFF;
    @(negedge clk);
    release dut.score_q;
    push("sat_pre", 16'hFFFF);
    pop_chk(score);
    set_bullet(190, 210, 90, 110);
    firing = 1'b1;
    push("sat_score", 16'hFFFF); push("sat_hit", 1); push("sat_alive", 4'hD);
    strobe(1);
    pop_chk(score); pop_chk(hit); pop_chk(alive);
    firing = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
